// File: rtl/fb_read_arbiter_pkg.sv
// Shared constants and types for the frame-buffer read-port arbiter.
package fb_read_arbiter_pkg;

    localparam int PX_WIDTH  = 256;
    localparam int PX_HEIGHT = 240;
    localparam int ADDR_W    = $clog2(PX_WIDTH * PX_HEIGHT);
    localparam int DATA_W    = 3;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

    // One in-flight read: who gets the data, and whether an A request was dropped for it.
    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   miss;
    } tag_t;

endpackage

// File: rtl/fb_read_arbiter_if.sv
// Read-port bundle between the arbiter (slave), the two requesters and the pixel memory (master).
interface fb_read_arbiter_if #(
    parameter int ADDR_W = fb_read_arbiter_pkg::ADDR_W,
    parameter int DATA_W = fb_read_arbiter_pkg::DATA_W
);

    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_vld;
    logic [DATA_W-1:0] a_data;
    logic              a_miss;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic              b_gnt;
    logic              b_vld;
    logic [DATA_W-1:0] b_data;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport slave (
        input  a_req, a_addr, b_req, b_addr, mem_data,
        output a_vld, a_data, a_miss, b_gnt, b_vld, b_data, mem_rd, mem_addr
    );

    modport master (
        output a_req, a_addr, b_req, b_addr, mem_data,
        input  a_vld, a_data, a_miss, b_gnt, b_vld, b_data, mem_rd, mem_addr
    );

endinterface

// File: rtl/fb_tag_pipe.sv
// DEPTH-stage shift register of read tags that tracks each read until its memory data returns.
module fb_tag_pipe import fb_read_arbiter_pkg::*; #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic flush,
    input  tag_t push,
    output tag_t head
);

    tag_t stage [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage samples the
    // pre-edge value of its neighbour; blocking here would collapse the shift into one cycle.
    // NOTE: no async reset on the stages; flush, held high through reset, clears the older
    // entries while stage 0 still accepts the cycle's push so no post-reset grant is lost.
    always_ff @(posedge clk) begin
        stage[0] <= push;
        for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= flush ? '0 : stage[i-1];
        end
    end

    assign head = stage[DEPTH-1];

endmodule

// File: rtl/fb_read_arbiter.sv
// Single memory read port shared by VGA scanout (A, priority) and capture (B, bounded wait).
// Optional build macro FB_ARB_STATS_EN adds saturating miss/force statistics counters.
module fb_read_arbiter #(
    parameter int ADDR_W   = fb_read_arbiter_pkg::ADDR_W,
    parameter int DATA_W   = fb_read_arbiter_pkg::DATA_W,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    fb_read_arbiter_if.slave        bus
`ifdef FB_ARB_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [15:0]             stat_a_miss,
    output logic [15:0]             stat_b_force
`endif
);

    import fb_read_arbiter_pkg::*;

    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              force_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              drop_a;
    logic [ADDR_W-1:0] addr_sel;
    tag_t              push;
    tag_t              head;
    logic              flush_q;
    logic              a_vld_q;
    logic              b_vld_q;
    logic              a_miss_q;
    logic [DATA_W-1:0] a_data_q;
    logic [DATA_W-1:0] b_data_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= NORMAL;
        end else begin
            state <= state_nxt;
        end
    end

    // FORCE is entered on the cycle the wait counter reaches MAX_WAIT; b_req is held until granted.
    always_comb begin
        state_nxt = NORMAL;
        if (MAX_WAIT > 0 && bus.b_req && !gnt_b && wait_cnt == WAIT_MAX - 1'b1) begin
            state_nxt = FORCE;
        end
    end

    // The counter term covers MAX_WAIT=0, where every B request is forced with no lead-in cycle.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        force_b  = bus.b_req && (state == FORCE || wait_cnt == WAIT_MAX);
        gnt_b    = bus.b_req && (!bus.a_req || force_b);
        gnt_a    = bus.a_req && !gnt_b;
        drop_a   = bus.a_req && gnt_b;
        addr_sel = '0;
        if (gnt_b) begin
            addr_sel = bus.b_addr;
        end else if (gnt_a) begin
            addr_sel = bus.a_addr;
        end
        push = '{valid: gnt_a || gnt_b, owner: gnt_b ? OWN_B : OWN_A, miss: drop_a};
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wait_cnt <= '0;
        end else if (gnt_b) begin
            wait_cnt <= '0;
        end else if (bus.b_req && wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            flush_q <= 1'b1;
        end else begin
            flush_q <= 1'b0;
        end
    end

    fb_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
        .clk   (clk),
        .flush (flush_q),
        .push  (push),
        .head  (head)
    );

    // The exit tag lines up with mem_data, so the capture register adds the final cycle of latency.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            a_vld_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            a_miss_q <= 1'b0;
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            a_vld_q  <= head.valid && head.owner == OWN_A;
            b_vld_q  <= head.valid && head.owner == OWN_B;
            a_miss_q <= head.valid && head.miss;
            if (head.valid && head.owner == OWN_A) begin
                a_data_q <= bus.mem_data;
            end
            if (head.valid && head.owner == OWN_B) begin
                b_data_q <= bus.mem_data;
            end
        end
    end

    assign bus.b_gnt    = gnt_b;
    assign bus.mem_rd   = gnt_a || gnt_b;
    assign bus.mem_addr = addr_sel;
    assign bus.a_vld    = a_vld_q;
    assign bus.b_vld    = b_vld_q;
    assign bus.a_miss   = a_miss_q;
    assign bus.a_data   = a_data_q;
    assign bus.b_data   = b_data_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] miss_cnt;
    logic [15:0] force_cnt;

    // The miss counter steps on the edge that raises a_miss, so it already includes a visible pulse.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            miss_cnt  <= '0;
            force_cnt <= '0;
        end else if (stats_clr) begin
            miss_cnt  <= '0;
            force_cnt <= '0;
        end else begin
            if (head.valid && head.miss && miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
            if (gnt_b && force_b && force_cnt != 16'hFFFF) begin
                force_cnt <= force_cnt + 16'd1;
            end
        end
    end

    assign stat_a_miss  = miss_cnt;
    assign stat_b_force = force_cnt;
`endif

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Self-checking bench: two arbiters (MAX_WAIT=4 and MAX_WAIT=0) against a transaction-level model.
module tb_fb_read_arbiter;

    typedef struct packed {
        int         dut;
        int         due;
        bit         is_b;
        bit         miss;
        logic [2:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        a_req;
    logic [15:0] a_addr;
    logic        b_req_v  [2];
    logic [15:0] b_addr_v [2];

    logic        o_bgnt  [2];
    logic        o_mrd   [2];
    logic [15:0] o_maddr [2];
    logic        o_avld  [2];
    logic        o_bvld  [2];
    logic        o_amiss [2];
    logic [2:0]  o_ad    [2];
    logic [2:0]  o_bd    [2];

    logic [2:0]  img [65536];
    ev_t         evq [$];
    int          mw [2] = '{4, 0};
    int          wcnt [2];
    bit          pend [2];
    logic [15:0] baddr [2];
    logic [2:0]  exp_ad [2];
    logic [2:0]  exp_bd [2];
    int          m_force [2];
    int          m_miss [2];

    int total = 0;
    int bad   = 0;
    int cyc   = -1;

    always #5 clk = ~clk;

    fb_read_arbiter_if bus4 ();
    fb_read_arbiter_if bus0 ();

    assign bus4.a_req  = a_req;
    assign bus4.a_addr = a_addr;
    assign bus4.b_req  = b_req_v[0];
    assign bus4.b_addr = b_addr_v[0];
    assign bus0.a_req  = a_req;
    assign bus0.a_addr = a_addr;
    assign bus0.b_req  = b_req_v[1];
    assign bus0.b_addr = b_addr_v[1];

    // Single-port memory with one cycle of read latency; garbage when not read.
    always @(posedge clk) bus4.mem_data <= bus4.mem_rd ? img[bus4.mem_addr] : 3'($urandom);
    always @(posedge clk) bus0.mem_data <= bus0.mem_rd ? img[bus0.mem_addr] : 3'($urandom);

    assign o_bgnt[0]  = bus4.b_gnt;     assign o_bgnt[1]  = bus0.b_gnt;
    assign o_mrd[0]   = bus4.mem_rd;    assign o_mrd[1]   = bus0.mem_rd;
    assign o_maddr[0] = bus4.mem_addr;  assign o_maddr[1] = bus0.mem_addr;
    assign o_avld[0]  = bus4.a_vld;     assign o_avld[1]  = bus0.a_vld;
    assign o_bvld[0]  = bus4.b_vld;     assign o_bvld[1]  = bus0.b_vld;
    assign o_amiss[0] = bus4.a_miss;    assign o_amiss[1] = bus0.a_miss;
    assign o_ad[0]    = bus4.a_data;    assign o_ad[1]    = bus0.a_data;
    assign o_bd[0]    = bus4.b_data;    assign o_bd[1]    = bus0.b_data;

`ifdef FB_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] sam [2];
    logic [15:0] sbf [2];
`endif

    fb_read_arbiter #(.MEM_LAT(1), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .clr          (clr),
        .bus          (bus4)
`ifdef FB_ARB_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .stat_a_miss  (sam[0]),
        .stat_b_force (sbf[0])
`endif
    );

    fb_read_arbiter #(.MEM_LAT(1), .MAX_WAIT(0)) dut_strict (
        .clk          (clk),
        .clr          (clr),
        .bus          (bus0)
`ifdef FB_ARB_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .stat_a_miss  (sam[1]),
        .stat_b_force (sbf[1])
`endif
    );

    task automatic check(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs 2 ns after the edge, compare against the model 2 ns later.
    task automatic tick(input bit rst, input bit a, input logic [15:0] aa, input bit bnew, input logic [15:0] ba);
        bit          gb, ga, ea, eb, em;
        logic [15:0] exp_addr;
        @(posedge clk);
        cyc++;
        #2;
        clr    = !rst;
        a_req  = a && !rst;
        a_addr = aa;
        for (int d = 0; d < 2; d++) begin
            if (rst) pend[d] = 1'b0;
            else if (!pend[d] && bnew) begin
                pend[d]  = 1'b1;
                baddr[d] = ba;
            end
            b_req_v[d]  = pend[d];
            b_addr_v[d] = baddr[d];
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            ea = 0; eb = 0; em = 0;
            if (rst) begin
                wcnt[d] = 0; exp_ad[d] = '0; exp_bd[d] = '0;
                m_force[d] = 0; m_miss[d] = 0;
                for (int i = evq.size() - 1; i >= 0; i--) if (evq[i].dut == d) evq.delete(i);
            end
            for (int i = evq.size() - 1; i >= 0; i--) begin
                if (evq[i].dut == d && evq[i].due == cyc) begin
                    if (evq[i].miss) em = 1;
                    else if (evq[i].is_b) begin eb = 1; exp_bd[d] = evq[i].data; end
                    else begin ea = 1; exp_ad[d] = evq[i].data; end
                    evq.delete(i);
                end
            end
            gb = pend[d] && (!a_req || wcnt[d] >= mw[d]);
            ga = a_req && !gb;
            exp_addr = gb ? baddr[d] : (ga ? aa : 16'd0);
            check("b_gnt",    d, 16'(o_bgnt[d]),  16'(gb));
            check("mem_rd",   d, 16'(o_mrd[d]),   16'(gb || ga));
            check("mem_addr", d, o_maddr[d],      exp_addr);
            check("a_vld",    d, 16'(o_avld[d]),  16'(ea));
            check("b_vld",    d, 16'(o_bvld[d]),  16'(eb));
            check("a_miss",   d, 16'(o_amiss[d]), 16'(em));
            check("a_data",   d, 16'(o_ad[d]),    16'(exp_ad[d]));
            check("b_data",   d, 16'(o_bd[d]),    16'(exp_bd[d]));
            if (em) m_miss[d]++;
            if (gb && wcnt[d] >= mw[d]) m_force[d]++;
            if (gb) evq.push_back('{dut: d, due: cyc + 2, is_b: 1, miss: 0, data: img[baddr[d]]});
            if (ga) evq.push_back('{dut: d, due: cyc + 2, is_b: 0, miss: 0, data: img[aa]});
            if (gb && a_req) evq.push_back('{dut: d, due: cyc + 2, is_b: 0, miss: 1, data: 3'd0});
            if (gb) begin
                wcnt[d] = 0;
                pend[d] = 1'b0;
            end else if (pend[d] && wcnt[d] < mw[d]) begin
                wcnt[d]++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) img[i] = 3'($urandom);
        img[100] = 3'b101;
        clr = 1'b0; a_req = 1'b0; a_addr = '0;
        for (int d = 0; d < 2; d++) begin
            b_req_v[d] = 1'b0; b_addr_v[d] = '0; pend[d] = 1'b0; baddr[d] = '0;
        end
`ifdef FB_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) tick(1, 0, 16'd0, 0, 16'd0);

        // Single A read of address 100.
        tick(0, 1, 16'd100, 0, 16'd0);
        tick(0, 0, 16'd0, 0, 16'd0);
        tick(0, 0, 16'd0, 0, 16'd0);
        check("tp_single_a_data", 0, 16'(o_ad[0]), 16'h5);
        repeat (2) tick(0, 0, 16'd0, 0, 16'd0);

        // B alone at address 7: granted in the same cycle.
        tick(0, 0, 16'd0, 1, 16'd7);
        check("tp_b_alone_gnt", 0, 16'(o_bgnt[0]), 16'h1);
        repeat (3) tick(0, 0, 16'd0, 0, 16'd0);

        // Reset one cycle after an A grant: that read never returns.
        tick(0, 1, 16'd200, 0, 16'd0);
        tick(1, 0, 16'd0, 0, 16'd0);
        tick(0, 0, 16'd0, 0, 16'd0);
        check("tp_rst_no_vld", 0, 16'(o_avld[0]), 16'h0);
        repeat (2) tick(0, 0, 16'd0, 0, 16'd0);

        // Continuous A with B requesting every cycle, 20-cycle window from a clean reset.
        repeat (2) tick(1, 0, 16'd0, 0, 16'd0);
        for (int i = 0; i < 20; i++) begin
            tick(0, 1, 16'($urandom), 1, 16'($urandom));
            if (i == 3) check("tp_b_denied_c3", 0, 16'(o_bgnt[0]), 16'h0);
            if (i == 4) check("tp_b_forced_c4", 0, 16'(o_bgnt[0]), 16'h1);
        end
        tick(0, 0, 16'd0, 0, 16'd0);
`ifdef FB_ARB_STATS_EN
        check("stat_b_force", 0, sbf[0], 16'd4);
        check("stat_a_miss",  0, sam[0], 16'd3);
        check("stat_b_force", 1, sbf[1], 16'(m_force[1]));
        check("stat_a_miss",  1, sam[1], 16'(m_miss[1]));
        stats_clr = 1'b1;
        tick(0, 0, 16'd0, 0, 16'd0);
        stats_clr = 1'b0;
        tick(0, 0, 16'd0, 0, 16'd0);
        for (int d = 0; d < 2; d++) begin
            check("stat_clr_force", d, sbf[d], 16'd0);
            check("stat_clr_miss",  d, sam[d], 16'd0);
        end
`endif
        repeat (2) tick(0, 0, 16'd0, 0, 16'd0);

        // Random traffic with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) repeat (2) tick(1, 0, 16'd0, 0, 16'd0);
            tick(0, $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) == 0, 16'($urandom));
        end
        repeat (3) tick(0, 0, 16'd0, 0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_read_arbiter.md
Name: fb_read_arbiter

Overview:
- Shares the renderer's single pixel-memory read port between two requesters.
- Port A is VGA scanout: real-time, with priority.
- Port B is the frame-capture/dump reader: background, with a req/gnt handshake.
- Sits between vga640x480, the capture logic and the renderer memory. It replaces the second read port, so the memory needs only one.
- A bounded-wait rule keeps port B from starving during continuous scanout.

Parameters:
- ADDR_W, 16, pixel address width (covers PX_WIDTH*PX_HEIGHT).
- DATA_W, 3, pixel colour-code width.
- MEM_LAT, 1, memory read latency in cycles from address to data (1..4).
- MAX_WAIT, 8, number of denied port-B cycles before B is force-granted. 0 gives strict B priority.

Ports:
- clk  in  1  pixel/system clock.
- clr  in  1  asynchronous, active-low reset.
- a_req  in  1  scanout read request, single cycle, may be asserted every cycle.
- a_addr  in  ADDR_W  scanout pixel address.
- a_vld  out  1  a_data valid pulse.
- a_data  out  DATA_W  scanout pixel, held between pulses.
- a_miss  out  1  pulse marking an A request that was dropped for a forced B grant.
- b_req  in  1  capture request; held with b_addr stable until b_gnt.
- b_addr  in  ADDR_W  capture pixel address.
- b_gnt  out  1  same-cycle grant (combinational).
- b_vld  out  1  b_data valid pulse.
- b_data  out  DATA_W  capture pixel, held between pulses.
- mem_rd  out  1  read strobe to the memory.
- mem_addr  out  ADDR_W  read address to the memory (combinational mux).
- mem_data  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_rd.

Behaviour:
- Reset (clr=0, asynchronous):
  - Clears tag pipeline, wait counter and FSM (state NORMAL).
  - a_vld, b_vld, a_miss and b_gnt go to 0. a_data and b_data go to 0.
  - Reads in flight at reset are discarded and never produce a vld.
- FSM states:
  - NORMAL: A wins any conflict. Moves to FORCE when b_req=1 and wait_cnt==MAX_WAIT.
  - FORCE: B granted this cycle regardless of a_req. Always returns to NORMAL next cycle.
  - With MAX_WAIT=0, every cycle with b_req is a FORCE cycle.
- Grant rules, per cycle, at most one grant:
  - Neither requester: mem_rd=0, mem_addr=0.
  - Only a_req: grant A.
  - Only b_req: grant B (b_gnt=1).
  - Both, wait_cnt<MAX_WAIT: grant A; wait_cnt increments.
  - Both, wait_cnt==MAX_WAIT: grant B; the A request is dropped and a_miss pulses MEM_LAT+1 cycles later, aligned with where a_vld would have been.
- Wait counter:
  - Increments only on cycles with b_req=1 and b_gnt=0.
  - Saturates at MAX_WAIT.
  - Clears on b_gnt.
  - Holds when b_req=0.
- Tag pipeline:
  - MEM_LAT stages of {valid, owner}, shifting every cycle.
  - At the exit stage, mem_data is registered into a_data or b_data by owner, and the matching vld pulses for one cycle.
  - Latency is fixed: grant to vld = MEM_LAT+1 cycles.
  - Throughput is one read per cycle. Back-to-back grants to alternating owners never collide.
- Protocol violations (undefined behaviour): changing b_addr or dropping b_req while waiting for b_gnt. The bench asserts the handshake instead.

Optional Feature:
- Macro: FB_ARB_STATS_EN.
- When defined, adds outputs stat_a_miss (16 bit) and stat_b_force (16 bit).
  - stat_a_miss counts a_miss pulses.
  - stat_b_force counts FORCE grants.
  - Both saturate at 16'hFFFF, reset to 0, and clear on a stats_clr input pulse.
  - These feed the ssled score display in debug builds.
- When undefined, those ports and counters do not exist. Arbitration behaviour is identical either way.

Decomposition:
- Shared consts package:
  - PX_WIDTH, PX_HEIGHT, ADDR_W, DATA_W.
  - Owner encoding: OWN_A=1'b0, OWN_B=1'b1.
  - FSM state encoding: NORMAL, FORCE.
- One sub-module, fb_tag_pipe: parameterised MEM_LAT-deep valid/owner shift register, with a synchronous flush used only by reset.
- Arbitration and wait counter stay in the top.

Test Plan (MEM_LAT=1, MAX_WAIT=4 unless noted):
- Single A read: a_req=1, a_addr=16'd100 for one cycle, memory returns 3'b101 → mem_rd=1 with mem_addr=100 in that cycle; a_vld=1 with a_data=3'b101 two cycles later; b_vld stays 0.
- Continuous A with B waiting: a_req every cycle, b_req held from cycle 0 → b_gnt=0 for cycles 0–3, b_gnt=1 in cycle 4; a_miss pulses in cycle 6; b_vld in cycle 6 with memory data for b_addr; A served again from cycle 5.
- Idle A: b_req alone with b_addr=16'd7 → b_gnt in the same cycle, b_vld two cycles later; wait counter stays 0.
- Strict B (MAX_WAIT=0): a_req and b_req both held → every cycle grants B and every cycle produces an a_miss pulse (from cycle 2 on); a_vld never asserts.
- Reset mid-flight: clr pulled low one cycle after an A grant → no a_vld; all outputs read 0 during and after reset until the next grant.
- FB_ARB_STATS_EN build, rerun of the continuous-A-with-B-waiting case (MAX_WAIT=4) for 20 cycles → stat_b_force=4, stat_a_miss=3 (the fourth miss pulse lands after the window); stats_clr returns both to 0.
